// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// a programmable number of times. Define SEQGEN_GAP_EN for one idle cycle between repetitions.
module seq_pattern_gen #(
    parameter int PAT_W = 5,
    parameter int LEN_W = 3,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] PAT_W_C = CNT_W'(PAT_W);
    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
`ifdef SEQGEN_GAP_EN
        GAP  = 2'd2,
`endif
        FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] len_clamp;
    logic [REP_W-1:0] reps_eff;
    logic [PAT_W-1:0] pat_aligned;

    // Pattern is stored left-aligned so the bit on the wire is always the MSB.
    assign len_clamp   = (len > PAT_W_L) ? PAT_W_C : CNT_W'(len);
    assign reps_eff    = (reps == '0) ? REP_W'(1) : reps;
    assign pat_aligned = pattern << (PAT_W_C - len_clamp);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shift_d   = shift_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        x_d       = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d     = pat_aligned;
                    len_d     = len_clamp;
                    rep_cnt_d = reps_eff - 1'b1;
                    if (len_clamp == '0) begin
                        state_d   = FIN;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        state_d   = SEND;
                        x_d       = pat_aligned[PAT_W-1];
                        shift_d   = pat_aligned << 1;
                        bit_cnt_d = len_clamp - 1'b1;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            SEND: begin
                // bit_cnt_q counts bits still to come after the one on the wire now.
                if (bit_cnt_q != '0) begin
                    x_d       = shift_q[PAT_W-1];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else if (rep_cnt_q != '0) begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
`ifdef SEQGEN_GAP_EN
                    state_d   = GAP;
                    busy_d    = 1'b1;
`else
                    x_d       = pat_q[PAT_W-1];
                    shift_d   = pat_q << 1;
                    bit_cnt_d = len_q - 1'b1;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
`endif
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                state_d   = SEND;
                x_d       = pat_q[PAT_W-1];
                shift_d   = pat_q << 1;
                bit_cnt_d = len_q - 1'b1;
                valid_d   = 1'b1;
                busy_d    = 1'b1;
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected bits/done events carry their cycle number.
// Handshake: an event is any cycle with valid=1 (one pattern bit) or done=1 (end of stream).
module tb_seq_pattern_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] pattern;
    logic [2:0] len;
    logic [3:0] reps;
    logic       x, valid, busy, done;

    seq_pattern_gen #(.PAT_W(5), .LEN_W(3), .REP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .x(x), .valid(valid), .busy(busy), .done(done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [35:0] exp_q[$];            // {cycle, done, valid, busy, x}
    logic        cap_en = 1'b0;
    logic [63:0] cap    = '0;
    int          cap_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int count_11011(input logic [63:0] v, input int n);
        int c = 0;
        for (int i = 0; i + 5 <= n; i++)
            if (v[i +: 5] == 5'b11011) c++;
        return c;
    endfunction

    logic [35:0] mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0][35:4] < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event actual=none required=%b at cycle %0d",
                         exp_q[0][3:0], exp_q[0][35:4]);
                void'(exp_q.pop_front());
            end
            if (!valid) check("x_zero_without_valid", 32'(x), 32'd0);
            if (valid || done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=%b required=none (cycle %0d)",
                             {done, valid, busy, x}, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_cycle", cyc, mon_e[35:4]);
                    check("event_value", 32'({done, valid, busy, x}), 32'(mon_e[3:0]));
                end
            end
            if (cap_en && busy) begin
                cap   = {cap[62:0], x};
                cap_n = cap_n + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Expected stream: pat[l-1..0] repeated r times, first bit in cycle s, done after the last.
    task automatic push_stream(input int unsigned s, input logic [4:0] pat, input int l, input int r);
        int unsigned t = s;
        for (int rep = 0; rep < r; rep++) begin
            for (int b = l - 1; b >= 0; b--) begin
                exp_q.push_back({t, 1'b0, 1'b1, 1'b1, pat[b]});
                t++;
            end
`ifdef SEQGEN_GAP_EN
            if (rep < r - 1) t++;
`endif
        end
        exp_q.push_back({t, 4'b1000});
    endtask

    task automatic issue(input logic [4:0] pat, input logic [2:0] l_in, input logic [3:0] r_in,
                         input int exp_l, input int exp_r);
        @(negedge clk);
        pattern = pat;
        len     = l_in;
        reps    = r_in;
        start   = 1'b1;
        push_stream(cyc + 1, pat, exp_l, exp_r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_x"}, 32'(x), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single 11011
        issue(5'b11011, 3'd5, 4'd1, 5, 1);
        drain("drain_single");

        // three repetitions, also captured as a raw stream
        cap    = '0;
        cap_n  = 0;
        cap_en = 1'b1;
        issue(5'b11011, 3'd5, 4'd3, 5, 3);
        drain("drain_reps3");
        cap_en = 1'b0;
`ifdef SEQGEN_GAP_EN
        check("stream_len", cap_n, 17);
        check("stream_bits", cap[31:0], 32'(17'b11011011011011011));
        check("detector_hits", count_11011(cap, cap_n), 5);
`else
        check("stream_len", cap_n, 15);
        check("stream_bits", cap[31:0], 32'(15'b110111101111011));
        check("detector_hits", count_11011(cap, cap_n), 3);
`endif

        // length / repetition boundaries
        issue(5'b10101, 3'd0, 4'd2, 0, 1);   // len=0: done only
        drain("drain_len0");
        issue(5'b10110, 3'd7, 4'd2, 5, 2);   // len clamps to 5
        drain("drain_len7");
        issue(5'b00101, 3'd3, 4'd0, 3, 1);   // reps=0 acts as 1
        drain("drain_reps0");
        issue(5'b11110, 3'd1, 4'd2, 1, 2);   // single-bit pattern of 0
        drain("drain_len1");

        // start held and inputs changed while busy; restart from the cycle after done
        @(negedge clk);
        pattern = 5'b11011;
        len     = 3'd5;
        reps    = 4'd1;
        start   = 1'b1;
        push_stream(cyc + 1, 5'b11011, 5, 1);
        @(negedge clk);
        pattern = 5'b00000;
        len     = 3'd2;
        reps    = 4'd7;
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        check("done_seen", 32'(done), 32'd1);
        pattern = 5'b10011;
        len     = 3'd5;
        reps    = 4'd1;
        start   = 1'b1;
        push_stream(cyc + 2, 5'b10011, 5, 1);
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain("drain_restart");

        // asynchronous reset during the third bit aborts without done
        @(negedge clk);
        pattern = 5'b11011;
        len     = 3'd5;
        reps    = 4'd2;
        start   = 1'b1;
        push_stream(cyc + 1, 5'b11011, 5, 2);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(5'b11011, 3'd5, 4'd1, 5, 1);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
